key_schedule_seq: RTL and testbench

- Sequential AES-128 key-expansion controller.
- Loads a 128-bit cipher key and steps through rounds 1..10.
- For each round it drives the round-constant stage: round index plus the SubWord(RotWord(w3)) bytes. It consumes the returned 32-bit word and forms the next round key.
- Sits directly upstream of the round-constant stage and feeds round keys to the cipher datapath through a valid/ready handshake.

---
 rtl/aes_pkg.sv | 16 +
 rtl/sbox_word.sv | 31 +++
 rtl/key_schedule_seq.sv | 126 ++++++++++++
 tb/tb_key_schedule_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 key-schedule constants, FSM encoding and round-index type
package aes_pkg;

    localparam int NR     = 10;
    localparam int KEY_W  = 128;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        DONE    = 2'd2
    } state_e;

    typedef logic [3:0] round_t;

endpackage

// File: rtl/sbox_word.sv
// sbox_word: combinational SubWord, four independent AES S-box byte lookups
module sbox_word (
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    // Row-major S-box; byte 0 is the most significant byte of the literal.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    for (genvar g = 0; g < 4; g++) begin : g_byte
        assign word_o[8*g +: 8] = SBOX[word_i[8*g +: 8]];
    end

endmodule

// File: rtl/key_schedule_seq.sv
// key_schedule_seq: sequential AES-128 key expansion with valid/ready round-key output.
// Optional KEY_STORE_EN builds an 11-entry round-key store with a combinational read port.
module key_schedule_seq #(
    parameter int NR    = 10,
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_in,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy_out,
    output logic             rk_valid_out,
    input  logic             rk_ready_in,
    output logic [KEY_W-1:0] round_key_out,
    output logic [3:0]       round_idx_out,
    output logic             done_out,
    output logic [3:0]       rc_round_out,
    output logic [7:0]       rc_b0_out,
    output logic [7:0]       rc_b1_out,
    output logic [7:0]       rc_b2_out,
    output logic [7:0]       rc_b3_out,
    input  logic [31:0]      rc_word_in,
    input  logic [3:0]       rk_rd_idx_in,
    output logic [KEY_W-1:0] rk_rd_data_out
);

    import aes_pkg::*;

    state_e             state_q;
    round_t             round_q;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               busy_q, valid_q, done_q;
    logic               hs, rc_act;
    logic [WORD_W-1:0]  w0, w1, w2, w3, n0, n1, n2, n3, sub_w;

    assign {w0, w1, w2, w3} = key_q;
    assign hs     = valid_q && rk_ready_in;
    assign rc_act = (state_q == PRESENT) && (round_q < round_t'(NR));

    // SubWord(RotWord(w3)) feeds the round-constant stage
    sbox_word u_sbox (
        .word_i ({w3[23:0], w3[31:24]}),
        .word_o (sub_w)
    );

    // Request lines stay quiet outside active rounds so idle/reset outputs read zero
    assign rc_round_out = rc_act ? round_q + 4'd1 : 4'd0;
    assign {rc_b0_out, rc_b1_out, rc_b2_out, rc_b3_out} = rc_act ? sub_w : '0;

    // Next round key chains the returned word through the current four words
    always_comb begin
        n0    = rc_word_in ^ w0;
        n1    = n0 ^ w1;
        n2    = n1 ^ w2;
        n3    = n2 ^ w3;
        key_d = {n0, n1, n2, n3};
    end

    // Control FSM; every output it drives is registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            round_q <= '0;
            key_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_in) begin
                        key_q   <= key_in;
                        round_q <= '0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (hs && round_q < round_t'(NR)) begin
                        key_q   <= key_d;
                        round_q <= round_q + 4'd1;
                    end else if (hs) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_out      = busy_q;
    assign rk_valid_out  = valid_q;
    assign round_key_out = key_q;
    assign round_idx_out = round_q;
    assign done_out      = done_q;

`ifdef KEY_STORE_EN
    logic [KEY_W-1:0] store_q [NR+1];

    // Capture each round key as it is handed off, for reverse-order reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NR; i++) store_q[i] <= '0;
        end else if (hs) begin
            store_q[round_q] <= key_q;
        end
    end

    assign rk_rd_data_out = (rk_rd_idx_in <= round_t'(NR)) ? store_q[rk_rd_idx_in] : '0;
`else
    logic unused_rd;

    assign unused_rd      = ^rk_rd_idx_in;
    assign rk_rd_data_out = '0;
`endif

endmodule

// File: tb/tb_key_schedule_seq.sv
// tb_key_schedule_seq: scoreboard bench for key_schedule_seq with a behavioural round-constant stage
module tb_key_schedule_seq;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
        bit           ck;
    } exp_t;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2_R1    = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] K2_R10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic [127:0] fips_rk [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_in = 1'b0;
    logic [127:0] key_in = '0;
    logic         busy_out, rk_valid_out, done_out;
    logic         rk_ready_in = 1'b0;
    logic [127:0] round_key_out, rk_rd_data_out;
    logic [3:0]   round_idx_out, rc_round_out;
    logic [7:0]   rc_b0_out, rc_b1_out, rc_b2_out, rc_b3_out;
    logic [31:0]  rc_word_in;
    logic [3:0]   rk_rd_idx_in = '0;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb [$];

    always #5 clk = ~clk;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign rc_word_in = {rc_b0_out ^ rcon(rc_round_out), rc_b1_out, rc_b2_out, rc_b3_out};

    key_schedule_seq dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_in       (start_in),
        .key_in         (key_in),
        .busy_out       (busy_out),
        .rk_valid_out   (rk_valid_out),
        .rk_ready_in    (rk_ready_in),
        .round_key_out  (round_key_out),
        .round_idx_out  (round_idx_out),
        .done_out       (done_out),
        .rc_round_out   (rc_round_out),
        .rc_b0_out      (rc_b0_out),
        .rc_b1_out      (rc_b1_out),
        .rc_b2_out      (rc_b2_out),
        .rc_b3_out      (rc_b3_out),
        .rc_word_in     (rc_word_in),
        .rk_rd_idx_in   (rk_rd_idx_in),
        .rk_rd_data_out (rk_rd_data_out)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    // Scores any handshake about to happen at the next edge, then advances one cycle
    task automatic tick();
        exp_t e;
        #1;
        if (rk_valid_out && rk_ready_in) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 128'(sb.size()), 128'd1);
            end else begin
                e = sb.pop_front();
                chk("rk_idx", 128'(round_idx_out), 128'(e.idx));
                if (e.ck) chk("rk_key", round_key_out, e.key);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_outs(input string tag);
        chk(tag, 128'({busy_out, rk_valid_out, done_out, round_idx_out, rc_round_out,
                       rc_b0_out, rc_b1_out, rc_b2_out, rc_b3_out}), 128'd0);
        chk({tag, "_key"}, round_key_out, 128'd0);
    endtask

    task automatic run(input logic [127:0] key, input bit is_fips,
                       input int bp_at, input int ign_at, input int rst_at);
        int cyc = 0;
        int vcnt = 0;
        bit fin = 0, bp_done = 0, ign_done = 0, r10_done = 0, aborted = 0;
        logic [127:0] last;
        for (int r = 0; r <= 10; r++) begin
            exp_t e;
            e.idx = 4'(r);
            e.key = is_fips ? fips_rk[r] : (r == 1 ? K2_R1 : K2_R10);
            e.ck  = is_fips || r == 1 || r == 10;
            sb.push_back(e);
        end
        last = is_fips ? fips_rk[10] : K2_R10;
        key_in = key;
        start_in = 1'b1;
        rk_ready_in = 1'b1;
        tick();
        start_in = 1'b0;
        chk("start_valid", 128'(rk_valid_out), 128'd1);
        chk("start_busy", 128'(busy_out), 128'd1);
        if (is_fips) begin
            chk("rc_round1", 128'(rc_round_out), 128'd1);
            chk("rc_bytes1", 128'({rc_b0_out, rc_b1_out, rc_b2_out, rc_b3_out}), 128'h8a84eb01);
            chk("rc_word1", 128'(rc_word_in), 128'h8b84eb01);
        end
        while (!fin && !aborted && cyc < 100) begin
            if (rk_valid_out) vcnt++;
            if (int'(round_idx_out) == 10 && !r10_done) begin
                r10_done = 1;
                chk("rc_round10", 128'(rc_round_out), 128'd0);
            end
            if (int'(round_idx_out) == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk_zero_outs("abort_outs");
                sb.delete();
                @(posedge clk);
                #1;
                chk("abort_no_done", 128'(done_out), 128'd0);
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                aborted = 1;
            end else begin
                if (int'(round_idx_out) == bp_at && !bp_done) begin
                    bp_done = 1;
                    rk_ready_in = 1'b0;
                    repeat (5) begin
                        tick();
                        chk("bp_key", round_key_out, fips_rk[3]);
                        chk("bp_idx", 128'(round_idx_out), 128'd3);
                        chk("bp_valid", 128'(rk_valid_out), 128'd1);
                    end
                    rk_ready_in = 1'b1;
                end
                if (int'(round_idx_out) == ign_at && !ign_done) begin
                    ign_done = 1;
                    key_in = ~key;
                    start_in = 1'b1;
                end
                tick();
                start_in = 1'b0;
                key_in = key;
                cyc++;
                if (done_out) fin = 1;
            end
        end
        if (!aborted) begin
            if (!fin) chk("timeout", 128'(done_out), 128'd1);
            chk("done_sb_left", 128'(sb.size()), 128'd0);
            chk("valid_cycles", 128'(vcnt), 128'd11);
            chk("done_latency", 128'(cyc), 128'd11);
            chk("done_busy", 128'(busy_out), 128'd0);
            chk("done_valid", 128'(rk_valid_out), 128'd0);
            chk("hold_key", round_key_out, last);
            tick();
            chk("done_pulse", 128'(done_out), 128'd0);
            chk("idle_busy", 128'(busy_out), 128'd0);
            chk("idle_key", round_key_out, last);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outs("reset_outs");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_after_reset", 128'(busy_out), 128'd0);
        run(FIPS_KEY, 1, -1, -1, -1);
`ifdef KEY_STORE_EN
        rk_rd_idx_in = 4'd10;
        #1;
        chk("store10", rk_rd_data_out, fips_rk[10]);
        rk_rd_idx_in = 4'd0;
        #1;
        chk("store0", rk_rd_data_out, FIPS_KEY);
        rk_rd_idx_in = 4'd5;
        #1;
        chk("store5", rk_rd_data_out, fips_rk[5]);
        rk_rd_idx_in = 4'd12;
        #1;
        chk("store12", rk_rd_data_out, 128'd0);
`else
        rk_rd_idx_in = 4'd0;
        #1;
        chk("store_tied", rk_rd_data_out, 128'd0);
`endif
        run(FIPS_KEY, 1, 3, -1, -1);
        run(FIPS_KEY, 1, -1, 5, -1);
        run(FIPS_KEY, 1, -1, -1, 6);
        run(K2_KEY, 0, -1, -1, -1);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
